// File: rtl/cpu_loader_pkg.sv
// cpu_loader_pkg: shared definitions for the cpu_loader boot loader.
// Holds the FSM state type, the header command codes and the header field
// positions, together with small helpers that extract the header fields.
package cpu_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_IMEM    = 3'd1,
    ST_DMEM_LO = 3'd2,
    ST_DMEM_HI = 3'd3,
    ST_DRAIN   = 3'd4,
    ST_CSUM    = 3'd5,
    ST_RUN     = 3'd6
  } state_t;

  localparam logic [3:0] CMD_LOAD_IMEM = 4'h1;
  localparam logic [3:0] CMD_LOAD_DMEM = 4'h2;
  localparam logic [3:0] CMD_RUN       = 4'h3;

  localparam int unsigned HDR_CMD_LSB = 28;
  localparam int unsigned HDR_CMD_W   = 4;
  localparam int unsigned HDR_N_LSB   = 0;
  localparam int unsigned HDR_N_W     = 16;

  function automatic logic [3:0] hdr_cmd(input logic [31:0] w);
    return w[HDR_CMD_LSB +: HDR_CMD_W];
  endfunction

  function automatic logic [15:0] hdr_n(input logic [31:0] w);
    return w[HDR_N_LSB +: HDR_N_W];
  endfunction

endpackage

// File: rtl/cpu_loader_if.sv
// cpu_loader_if: command stream plus instruction/data memory write ports and
// CPU control outputs of the boot loader.
//   s_valid/s_ready/s_data        : 32-bit valid/ready command stream
//   addr_ext/wen_ext/ren_ext/wdata_ext          : imem write port (32-bit data)
//   addr_ext_2/wen_ext_2/ren_ext_2/wdata_ext_2  : dmem write port (64-bit data)
//   enable, busy, err             : CPU run enable, loader busy, sticky error
// master = loader side, slave = stream source / memory / CPU side.
interface cpu_loader_if;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic [63:0] addr_ext;
  logic        wen_ext;
  logic        ren_ext;
  logic [31:0] wdata_ext;
  logic [63:0] addr_ext_2;
  logic        wen_ext_2;
  logic        ren_ext_2;
  logic [63:0] wdata_ext_2;
  logic        enable;
  logic        busy;
  logic        err;

  modport master (
    input  s_valid, s_data,
    output s_ready,
    output addr_ext, wen_ext, ren_ext, wdata_ext,
    output addr_ext_2, wen_ext_2, ren_ext_2, wdata_ext_2,
    output enable, busy, err
  );

  modport slave (
    output s_valid, s_data,
    input  s_ready,
    input  addr_ext, wen_ext, ren_ext, wdata_ext,
    input  addr_ext_2, wen_ext_2, ren_ext_2, wdata_ext_2,
    input  enable, busy, err
  );
endinterface

// File: rtl/cpu_loader_csum.sv
// cpu_loader_csum: 32-bit XOR accumulator for frame checksums.
//   clk, srst : clock, synchronous active-high reset
//   clr       : zero the accumulator (frame header)
//   acc_en    : fold din into the accumulator (payload beat)
//   din       : payload word
//   acc       : running XOR of payload words since the last clear
module cpu_loader_csum (
  input  logic        clk,
  input  logic        srst,
  input  logic        clr,
  input  logic        acc_en,
  input  logic [31:0] din,
  output logic [31:0] acc
);

  always_ff @(posedge clk) begin
    if (srst || clr) acc <= '0;
    else if (acc_en) acc <= acc ^ din;
  end

endmodule

// File: rtl/cpu_loader.sv
// cpu_loader: boot loader writing imem/dmem contents from a 32-bit command
// stream and raising the CPU enable on a RUN command.
//   clk  : clock, rising edge
//   srst : synchronous active-high reset
//   bus  : cpu_loader_if.master (stream in, memory write ports, enable/busy/err)
// Parameters: IMEM_WORDS (32-bit words), DMEM_WORDS (64-bit words).
// Optional feature: define CPU_LOADER_CHECKSUM_EN to require a trailing XOR
// checksum word after every LOAD frame.
module cpu_loader
  import cpu_loader_pkg::*;
#(
  parameter int unsigned IMEM_WORDS = 128,
  parameter int unsigned DMEM_WORDS = 128
) (
  input logic          clk,
  input logic          srst,
  cpu_loader_if.master bus
);

`ifdef CPU_LOADER_CHECKSUM_EN
  localparam logic [16:0] CSUM_EXTRA = 17'd1;
  localparam state_t      PAY_DONE   = ST_CSUM;
`else
  localparam logic [16:0] CSUM_EXTRA = 17'd0;
  localparam state_t      PAY_DONE   = ST_IDLE;
`endif

  state_t      state, nxt;
  logic [15:0] idx, cnt_n;
  logic [16:0] drain_left;
  logic [31:0] lo_half;
  logic        rdy_q, wen_i, wen_d, enable_q, busy_q, err_q, err_set;
  logic [63:0] addr_i, addr_d, wdata_d;
  logic [31:0] wdata_i;
  logic        beat, last;
  logic [3:0]  cmd;
  logic [15:0] n_hdr;

  // Ready is gated by srst so no beat can be accepted while reset is held;
  // the registered part comes out of reset already high.
  assign bus.s_ready     = rdy_q & ~srst;
  assign beat            = bus.s_valid & bus.s_ready;
  assign cmd             = hdr_cmd(bus.s_data);
  assign n_hdr           = hdr_n(bus.s_data);
  assign last            = (idx == cnt_n - 16'd1);

  assign bus.addr_ext    = addr_i;
  assign bus.wen_ext     = wen_i;
  assign bus.ren_ext     = 1'b0;
  assign bus.wdata_ext   = wdata_i;
  assign bus.addr_ext_2  = addr_d;
  assign bus.wen_ext_2   = wen_d;
  assign bus.ren_ext_2   = 1'b0;
  assign bus.wdata_ext_2 = wdata_d;
  assign bus.enable      = enable_q;
  assign bus.busy        = busy_q;
  assign bus.err         = err_q;

`ifdef CPU_LOADER_CHECKSUM_EN
  logic [31:0] csum_acc;
  logic        csum_clr, csum_en;

  assign csum_clr = beat && (state == ST_IDLE);
  assign csum_en  = beat && (state == ST_IMEM || state == ST_DMEM_LO ||
                             state == ST_DMEM_HI);

  cpu_loader_csum u_csum (
    .clk    (clk),
    .srst   (srst),
    .clr    (csum_clr),
    .acc_en (csum_en),
    .din    (bus.s_data),
    .acc    (csum_acc)
  );
`endif

  always_comb begin
    nxt     = state;
    err_set = 1'b0;
    if (beat) begin
      case (state)
        ST_IDLE: begin
          case (cmd)
            CMD_LOAD_IMEM: begin
              if (n_hdr == 16'd0) nxt = PAY_DONE;
              else if (32'(n_hdr) > IMEM_WORDS) begin
                err_set = 1'b1;
                nxt     = ST_DRAIN;
              end else nxt = ST_IMEM;
            end
            CMD_LOAD_DMEM: begin
              if (n_hdr == 16'd0) nxt = PAY_DONE;
              else if (32'(n_hdr) > DMEM_WORDS) begin
                err_set = 1'b1;
                nxt     = ST_DRAIN;
              end else nxt = ST_DMEM_LO;
            end
            CMD_RUN: nxt = ST_RUN;
            default: err_set = 1'b1;
          endcase
        end
        ST_IMEM:    if (last) nxt = PAY_DONE;
        ST_DMEM_LO: nxt = ST_DMEM_HI;
        ST_DMEM_HI: nxt = last ? PAY_DONE : ST_DMEM_LO;
        ST_DRAIN:   if (drain_left == 17'd1) nxt = ST_IDLE;
`ifdef CPU_LOADER_CHECKSUM_EN
        ST_CSUM: begin
          nxt     = ST_IDLE;
          err_set = (bus.s_data != csum_acc);
        end
`endif
        ST_RUN:     nxt = ST_RUN;
        default:    nxt = ST_IDLE;
      endcase
    end
  end

  // Status outputs are computed from the next state so they are registered
  // yet line up with the cycle in which the new state is visible.
  always_ff @(posedge clk) begin
    if (srst) begin
      state      <= ST_IDLE;
      idx        <= '0;
      cnt_n      <= '0;
      drain_left <= '0;
      lo_half    <= '0;
      rdy_q      <= 1'b1;
      wen_i      <= 1'b0;
      wen_d      <= 1'b0;
      addr_i     <= '0;
      wdata_i    <= '0;
      addr_d     <= '0;
      wdata_d    <= '0;
      enable_q   <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state    <= nxt;
      rdy_q    <= (nxt != ST_RUN);
      busy_q   <= !(nxt == ST_IDLE || nxt == ST_RUN);
      enable_q <= (nxt == ST_RUN);
      err_q    <= err_q | err_set;
      wen_i    <= 1'b0;
      wen_d    <= 1'b0;
      if (beat) begin
        case (state)
          ST_IDLE: begin
            idx        <= '0;
            cnt_n      <= n_hdr;
            drain_left <= ((cmd == CMD_LOAD_DMEM) ? {n_hdr, 1'b0} : {1'b0, n_hdr})
                          + CSUM_EXTRA;
          end
          ST_IMEM: begin
            wen_i   <= 1'b1;
            addr_i  <= {46'd0, idx, 2'b00};
            wdata_i <= bus.s_data;
            idx     <= idx + 16'd1;
          end
          ST_DMEM_LO: lo_half <= bus.s_data;
          ST_DMEM_HI: begin
            wen_d   <= 1'b1;
            addr_d  <= {45'd0, idx, 3'b000};
            wdata_d <= {bus.s_data, lo_half};
            idx     <= idx + 16'd1;
          end
          ST_DRAIN: drain_left <= drain_left - 17'd1;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cpu_loader.sv
// tb_cpu_loader: randomized scoreboard bench for cpu_loader. Frames are built
// from the command rules into a beat list; expected memory writes are queued
// when their beat is accepted and a monitor process checks every write strobe.
module tb_cpu_loader;

  localparam int unsigned IMEM_WORDS = 128;
  localparam int unsigned DMEM_WORDS = 128;
`ifdef CPU_LOADER_CHECKSUM_EN
  localparam bit CS = 1'b1;
`else
  localparam bit CS = 1'b0;
`endif

  logic clk  = 1'b0;
  logic srst = 1'b1;

  cpu_loader_if bus ();

  cpu_loader #(.IMEM_WORDS(IMEM_WORDS), .DMEM_WORDS(DMEM_WORDS)) dut (
    .clk  (clk),
    .srst (srst),
    .bus  (bus)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic [31:0] word;
    int          kind;        // 0 no write, 1 imem write, 2 dmem write
    logic [63:0] addr;
    logic [63:0] data;
    bit          busy_after;
  } beat_t;

  typedef struct {
    logic [63:0] addr;
    logic [63:0] data;
    int unsigned due;
  } wr_t;

  beat_t       beats_q[$];
  wr_t         imem_q[$];
  wr_t         dmem_q[$];
  logic [31:0] fixed_q[$];
  int unsigned compared   = 0;
  int unsigned mismatched = 0;
  int unsigned cyc        = 0;
  bit          exp_err    = 1'b0;
  bit          exp_en     = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every strobe must match the oldest expected write, one cycle
  // after its accepting beat.
  always @(negedge clk) begin
    wr_t w;
    if (bus.wen_ext === 1'b1) begin
      compared++;
      if (imem_q.size() == 0) begin
        mismatched++;
        $display("FAIL imem_write: unexpected write addr=%h data=%h", bus.addr_ext, bus.wdata_ext);
      end else begin
        w = imem_q.pop_front();
        if (bus.addr_ext !== w.addr || bus.wdata_ext !== w.data[31:0] || cyc != w.due) begin
          mismatched++;
          $display("FAIL imem_write: got addr=%h data=%h cyc=%0d expected addr=%h data=%h cyc=%0d",
                   bus.addr_ext, bus.wdata_ext, cyc, w.addr, w.data[31:0], w.due);
        end
      end
    end
    if (bus.wen_ext_2 === 1'b1) begin
      compared++;
      if (dmem_q.size() == 0) begin
        mismatched++;
        $display("FAIL dmem_write: unexpected write addr=%h data=%h", bus.addr_ext_2, bus.wdata_ext_2);
      end else begin
        w = dmem_q.pop_front();
        if (bus.addr_ext_2 !== w.addr || bus.wdata_ext_2 !== w.data || cyc != w.due) begin
          mismatched++;
          $display("FAIL dmem_write: got addr=%h data=%h cyc=%0d expected addr=%h data=%h cyc=%0d",
                   bus.addr_ext_2, bus.wdata_ext_2, cyc, w.addr, w.data, w.due);
        end
      end
    end
  end

  task automatic add_beat(input logic [31:0] word, input int kind, input logic [63:0] addr,
                          input logic [63:0] data, input bit busy_after);
    beat_t b;
    b.word = word; b.kind = kind; b.addr = addr; b.data = data; b.busy_after = busy_after;
    beats_q.push_back(b);
  endtask

  // Reference frame builder: header, payload (with expected writes), optional checksum.
  task automatic frame_load(input bit dmem, input int unsigned n, input bit bad_csum);
    logic [31:0] hdr, w, lo, x;
    logic [15:0] n16;
    int unsigned depth, npay;
    bit over, lastb;
    depth = dmem ? DMEM_WORDS : IMEM_WORDS;
    over  = (n > depth);
    npay  = dmem ? 2 * n : n;
    n16   = n[15:0];
    hdr   = {(dmem ? 4'h2 : 4'h1), 12'h000, n16};
    add_beat(hdr, 0, '0, '0, (npay > 0) || CS);
    x  = '0;
    lo = '0;
    for (int unsigned i = 0; i < npay; i++) begin
      if (fixed_q.size() > 0) w = fixed_q.pop_front();
      else w = $urandom();
      x = x ^ w;
      lastb = (i == npay - 1) && !CS;
      if (over) add_beat(w, 0, '0, '0, !lastb);
      else if (!dmem) add_beat(w, 1, 64'(i * 4), {32'd0, w}, !lastb);
      else if (i % 2 == 0) begin
        lo = w;
        add_beat(w, 0, '0, '0, !lastb);
      end else add_beat(w, 2, 64'((i / 2) * 8), {w, lo}, !lastb);
    end
    if (CS) add_beat(bad_csum ? (x ^ 32'd1) : x, 0, '0, '0, 1'b0);
    if (over || bad_csum) exp_err = 1'b1;
  endtask

  task automatic frame_illegal();
    logic [31:0] r;
    int unsigned c;
    logic [3:0] cmd;
    c   = $urandom_range(0, 12);
    cmd = (c == 0) ? 4'h0 : 4'(c + 3);
    r   = $urandom();
    add_beat({cmd, r[27:0]}, 0, '0, '0, 1'b0);
    exp_err = 1'b1;
  endtask

  task automatic run_beats(input bit final_chk);
    beat_t b;
    wr_t w;
    bit have_prev = 1'b0;
    bit prev_busy = 1'b0;
    int unsigned budget;
    while (beats_q.size() > 0) begin
      b = beats_q.pop_front();
      @(negedge clk);
      if (have_prev) chk("busy_between_beats", {63'd0, bus.busy}, {63'd0, prev_busy});
      if ($urandom_range(0, 3) == 0) begin
        bus.s_valid = 1'b0;
        repeat ($urandom_range(1, 2)) @(negedge clk);
      end
      bus.s_valid = 1'b1;
      bus.s_data  = b.word;
      budget = 0;
      while (bus.s_ready !== 1'b1 && budget < 50) begin
        @(negedge clk);
        budget++;
      end
      if (budget >= 50) begin
        compared++;
        mismatched++;
        $display("FAIL s_ready_timeout: got s_ready=%b expected 1 within 50 cycles", bus.s_ready);
      end
      @(posedge clk);
      if (b.kind != 0) begin
        w.addr = b.addr; w.data = b.data; w.due = cyc + 1;
        if (b.kind == 1) imem_q.push_back(w);
        else dmem_q.push_back(w);
      end
      have_prev = 1'b1;
      prev_busy = b.busy_after;
    end
    @(negedge clk);
    bus.s_valid = 1'b0;
    if (final_chk) begin
      chk("busy_after_frame", {63'd0, bus.busy}, {63'd0, prev_busy});
      chk("err", {63'd0, bus.err}, {63'd0, exp_err});
      chk("s_ready", {63'd0, bus.s_ready}, {63'd0, !exp_en});
      chk("enable", {63'd0, bus.enable}, {63'd0, exp_en});
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_addr_ext"}, bus.addr_ext, '0);
    chk({tag, "_wen_ext"}, {63'd0, bus.wen_ext}, '0);
    chk({tag, "_ren_ext"}, {63'd0, bus.ren_ext}, '0);
    chk({tag, "_wdata_ext"}, {32'd0, bus.wdata_ext}, '0);
    chk({tag, "_addr_ext_2"}, bus.addr_ext_2, '0);
    chk({tag, "_wen_ext_2"}, {63'd0, bus.wen_ext_2}, '0);
    chk({tag, "_ren_ext_2"}, {63'd0, bus.ren_ext_2}, '0);
    chk({tag, "_wdata_ext_2"}, bus.wdata_ext_2, '0);
    chk({tag, "_enable"}, {63'd0, bus.enable}, '0);
    chk({tag, "_busy"}, {63'd0, bus.busy}, '0);
    chk({tag, "_err"}, {63'd0, bus.err}, '0);
  endtask

  // One-cycle srst pulse starting at the next falling edge.
  task automatic do_reset();
    @(negedge clk);
    srst = 1'b1;
    bus.s_valid = 1'b0;
    #1 chk("s_ready_during_srst", {63'd0, bus.s_ready}, '0);
    @(negedge clk);
    chk_all_zero("rst");
    chk("s_ready_in_srst_cycle", {63'd0, bus.s_ready}, '0);
    srst = 1'b0;
    #1 chk("s_ready_first_idle", {63'd0, bus.s_ready}, 64'd1);
    exp_err = 1'b0;
    exp_en  = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    repeat (2) @(posedge clk);
    do_reset();

    // imem frame with two instruction words
    fixed_q.push_back(32'h00A0_0413);
    fixed_q.push_back(32'h0090_0493);
    frame_load(1'b0, 2, 1'b0);
    run_beats(1'b1);

    // dmem frame with one 64-bit word
    fixed_q.push_back(32'h3456_789A);
    fixed_q.push_back(32'h0000_0012);
    frame_load(1'b1, 1, 1'b0);
    run_beats(1'b1);

    // illegal command
    add_beat(32'h5000_0000, 0, '0, '0, 1'b0);
    exp_err = 1'b1;
    run_beats(1'b1);

    // reset right after the low half of a dmem pair
    add_beat(32'h2000_0001, 0, '0, '0, 1'b1);
    add_beat(32'hDEAD_BEEF, 0, '0, '0, 1'b1);
    run_beats(1'b0);
    do_reset();
    frame_load(1'b1, 2, 1'b0);
    run_beats(1'b1);

`ifdef CPU_LOADER_CHECKSUM_EN
    chk("err_before_csum", {63'd0, bus.err}, '0);
    fixed_q.push_back(32'h1234_5678);
    frame_load(1'b0, 1, 1'b1);
    run_beats(1'b1);
`endif

    // randomized back-to-back frames
    for (int f = 0; f < 25; f++) begin
      int unsigned r;
      r = $urandom_range(0, 9);
      if (r == 0) frame_illegal();
      else if (r == 1) frame_load($urandom_range(0, 1) == 1, $urandom_range(129, 131), 1'b0);
      else frame_load($urandom_range(0, 1) == 1, $urandom_range(0, 8), CS && (r == 2));
    end
    run_beats(1'b1);

    // oversized dmem frame is drained, then RUN
    frame_load(1'b1, 129, 1'b0);
    run_beats(1'b1);
    add_beat(32'h3000_0000, 0, '0, '0, 1'b0);
    exp_en = 1'b1;
    run_beats(1'b1);

    repeat (3) @(negedge clk);
    chk("enable_sticky", {63'd0, bus.enable}, 64'd1);
    chk("imem_pending", 64'(imem_q.size()), '0);
    chk("dmem_pending", 64'(dmem_q.size()), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
